// File: rtl/downsample_8x_fir.sv
// ---------------------------------------------------------------------------
// downsample_8x_fir
//   Decimating FIR filter. Taps are loaded once after reset/enable, then input
//   samples are collected G_DECIM at a time; after each block a sequential
//   multiply-accumulate over G_NUM_TAPS taps produces one output sample.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   enable       synchronous run enable; low behaves like reset
//   tap_wr       tap write strobe (one tap per cycle, LOAD only)
//   tap_val      signed Q1.15 tap, written in index order 0..G_NUM_TAPS-1
//   tap_wr_done  high once all taps are written
//   din/din_valid/din_ready     input stream (high rate)
//   dout/dout_valid/dout_ready  output stream (1/G_DECIM rate)
//
// Configuration
//   DOWNSAMPLE_8X_FIR_ROUNDING_EN  when defined, round half up before the
//                                  output shift; otherwise truncate (floor).
//
// state  | meaning
// LOAD   | waiting for G_NUM_TAPS tap writes
// ACCEPT | din_ready high, collecting one block of G_DECIM samples
// MAC    | one multiply-accumulate per cycle, then result registered
// OUT    | dout held until dout_ready
// ---------------------------------------------------------------------------
module downsample_8x_fir #(
    parameter int G_DWIDTH   = 24,
    parameter int G_TAP_RES  = 16,
    parameter int G_NUM_TAPS = 63,
    parameter int G_DECIM    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        tap_wr,
    input  logic signed [G_TAP_RES-1:0] tap_val,
    output logic                        tap_wr_done,
    input  logic signed [G_DWIDTH-1:0]  din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic signed [G_DWIDTH-1:0]  dout,
    output logic                        dout_valid,
    input  logic                        dout_ready
);

    localparam int AW     = $clog2(G_NUM_TAPS);
    localparam int PW     = (G_DECIM > 1) ? $clog2(G_DECIM) : 1;
    localparam int CW     = $clog2(G_NUM_TAPS + 2);
    localparam int PROD_W = G_DWIDTH + G_TAP_RES;
    localparam int ACC_W  = G_DWIDTH + G_TAP_RES + 6;

    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (G_DWIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2 ** (G_TAP_RES - 2));

    typedef enum logic [1:0] {LOAD, ACCEPT, MAC, OUT} state_t;

    state_t                      state;
    logic [AW-1:0]               tap_idx;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               rd_k;
    logic [PW-1:0]               phase;
    logic [CW-1:0]               mac_left;
    logic                        prod_vld;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     acc;

    logic signed [G_TAP_RES-1:0] taps  [G_NUM_TAPS];
    logic signed [G_DWIDTH-1:0]  dline [G_NUM_TAPS];

    logic                        accept;
    logic                        issue;
    logic [AW-1:0]               wr_ptr_nxt;
    logic [AW-1:0]               rd_ptr_nxt;
    logic signed [ACC_W-1:0]     acc_rnd;
    logic signed [ACC_W-1:0]     acc_sh;
    logic signed [G_DWIDTH-1:0]  res;

    assign accept     = (state == ACCEPT) && din_valid && din_ready;
    // mac_left runs G_NUM_TAPS+1 .. 0: products issue while it is above 1,
    // the last product drains into acc at 1, and the result registers at 0.
    assign issue      = (state == MAC) && (mac_left > CW'(1));
    assign wr_ptr_nxt = (wr_ptr == AW'(G_NUM_TAPS - 1)) ? '0 : wr_ptr + AW'(1);
    // Reading walks backwards in time from the newest sample.
    assign rd_ptr_nxt = (rd_ptr == '0) ? AW'(G_NUM_TAPS - 1) : rd_ptr - AW'(1);

    always_comb begin
`ifdef DOWNSAMPLE_8X_FIR_ROUNDING_EN
        acc_rnd = acc + RND;
`else
        acc_rnd = acc;
`endif
        acc_sh = acc_rnd >>> (G_TAP_RES - 1);
        res    = acc_sh[G_DWIDTH-1:0];
        if (acc_sh > MAXV) begin
            res = MAXV[G_DWIDTH-1:0];
        end else if (acc_sh < MINV) begin
            res = MINV[G_DWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            tap_idx     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_k        <= '0;
            phase       <= '0;
            mac_left    <= '0;
            prod_vld    <= 1'b0;
            prod        <= '0;
            acc         <= '0;
            tap_wr_done <= 1'b0;
            din_ready   <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
        end else if (!enable) begin
            state       <= LOAD;
            tap_idx     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_k        <= '0;
            phase       <= '0;
            mac_left    <= '0;
            prod_vld    <= 1'b0;
            prod        <= '0;
            acc         <= '0;
            tap_wr_done <= 1'b0;
            din_ready   <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (tap_wr) begin
                        if (tap_idx == AW'(G_NUM_TAPS - 1)) begin
                            tap_wr_done <= 1'b1;
                            din_ready   <= 1'b1;
                            state       <= ACCEPT;
                        end else begin
                            tap_idx <= tap_idx + AW'(1);
                        end
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr_nxt;
                        if (phase == PW'(G_DECIM - 1)) begin
                            phase     <= '0;
                            din_ready <= 1'b0;
                            rd_ptr    <= wr_ptr;
                            rd_k      <= '0;
                            mac_left  <= CW'(G_NUM_TAPS + 1);
                            acc       <= '0;
                            prod_vld  <= 1'b0;
                            state     <= MAC;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                end
                MAC: begin
                    prod_vld <= issue;
                    if (issue) begin
                        prod   <= PROD_W'(taps[rd_k]) * PROD_W'(dline[rd_ptr]);
                        rd_ptr <= rd_ptr_nxt;
                        rd_k   <= rd_k + AW'(1);
                    end
                    if (prod_vld) begin
                        acc <= acc + ACC_W'(prod);
                    end
                    if (mac_left == '0) begin
                        dout       <= res;
                        dout_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        mac_left <= mac_left - CW'(1);
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        din_ready  <= 1'b1;
                        state      <= ACCEPT;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Delay line is cleared so unwritten history contributes zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < G_NUM_TAPS; i++) dline[i] <= '0;
        end else if (!enable) begin
            for (int i = 0; i < G_NUM_TAPS; i++) dline[i] <= '0;
        end else if (accept) begin
            dline[wr_ptr] <= din;
        end
    end

    // Tap storage needs no reset: it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (!reset && enable && (state == LOAD) && tap_wr) begin
            taps[tap_idx] <= tap_val;
        end
    end

endmodule

// File: tb/tb_downsample_8x_fir.sv
module tb_downsample_8x_fir;

    localparam int DW = 24;
    localparam int TW = 16;
    localparam int LAT = 63 + 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 tap_wr;
    logic signed [TW-1:0] tap_val;
    logic                 tap_wr_done;
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_out = 0;
    int t_acc = 0;
    int base;

`ifdef DOWNSAMPLE_8X_FIR_ROUNDING_EN
    localparam int EXP_R29 = 2;
`else
    localparam int EXP_R29 = 1;
`endif

    downsample_8x_fir dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tap_wr      (tap_wr),
        .tap_val     (tap_val),
        .tap_wr_done (tap_wr_done),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && dout_valid && dout_ready) n_out <= n_out + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_taps(input int mode);
        for (int i = 0; i < 63; i++) begin
            case (mode)
                0:       tap_val = (i == 0) ? 16'sd16384 : 16'sd0;
                1:       tap_val = 16'sd32767;
                default: tap_val = (i == 0 || i == 7 || i == 8) ? 16'sd16384 : 16'sd0;
            endcase
            tap_wr = 1'b1;
            check("wr_done_low", tap_wr_done, 0);
            check("din_ready_low", din_ready, 0);
            tick();
        end
        tap_wr = 1'b0;
        check("wr_done_high", tap_wr_done, 1);
        check("din_ready_high", din_ready, 1);
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        check("en_lo_done", tap_wr_done, 0);
        check("en_lo_rdy", din_ready, 0);
        check("en_lo_vld", dout_valid, 0);
        check("en_lo_dout", dout, 0);
        enable = 1'b1;
    endtask

    task automatic send(input int val);
        int n = 0;
        while (!din_ready && n < 2000) begin
            tick();
            n++;
        end
        check("send_ready", din_ready, 1);
        din       = DW'(val);
        din_valid = 1'b1;
        tick();
        t_acc     = cyc;
        din_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp);
        int n = 0;
        while (!dout_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, dout_valid, 1);
        check({tag, "_latency"}, cyc - t_acc, LAT);
        check({tag, "_dout"}, dout, exp);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; tap_wr = 1'b0; tap_val = '0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_wr_done", tap_wr_done, 0);
        reset = 1'b0;
        tick();

        // Tap load, then stray tap writes outside LOAD must be ignored.
        load_taps(0);
        tap_wr = 1'b1; tap_val = '0;
        tick(); tick(); tick();
        tap_wr = 1'b0;
        check("ign_wr_done", tap_wr_done, 1);
        check("ign_din_ready", din_ready, 1);

        // tap[0]=0.5, ramp 1..16 -> outputs 4 and 8 only.
        base = n_out;
        for (int s = 1; s <= 16; s++) begin
            send(s);
            if (s == 7) begin
                check("r25_no_early_valid", dout_valid, 0);
                check("r25_no_early_out", n_out - base, 0);
            end
            if (s == 8)  wait_out("r25_a", 4);
            if (s == 16) wait_out("r25_b", 8);
        end
        tick(); tick();
        check("r25_count", n_out - base, 2);

        // Rounding: 3 * 0.5 = 1.5.
        for (int s = 0; s < 7; s++) send(0);
        send(3);
        wait_out("r29", EXP_R29);

        // Saturation, positive then negative with fresh history.
        restart();
        load_taps(1);
        for (int s = 0; s < 8; s++) send(8388607);
        wait_out("r26_pos", 8388607);
        tick();
        restart();
        load_taps(1);
        for (int s = 0; s < 8; s++) send(-8388608);
        wait_out("r26_neg", -8388608);
        tick();

        // Back-pressure: taps 0,7,8 = 0.5 -> (x[n]+x[n-7]+x[n-8])/2, input 2*s.
        restart();
        load_taps(2);
        base = n_out;
        dout_ready = 1'b0;
        for (int s = 1; s <= 8; s++) send(2 * s);
        wait_out("r27_a", 9);
        din = 24'sd18; din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("r27_hold_dout", dout, 9);
            check("r27_hold_valid", dout_valid, 1);
            check("r27_hold_rdy", din_ready, 0);
        end
        dout_ready = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        check("r27_first_out", n_out - base, 1);
        for (int s = 10; s <= 16; s++) begin
            if (s % 2 == 1) tick();
            send(2 * s);
        end
        dout_ready = 1'b0;
        wait_out("r27_b", 33);
        tick(); tick(); tick();
        check("r27_b_hold", dout, 33);
        dout_ready = 1'b1;
        for (int s = 17; s <= 24; s++) send(2 * s);
        wait_out("r27_c", 57);
        tick(); tick();
        check("r27_count", n_out - base, 3);

        // Reset during MAC discards the block.
        for (int s = 25; s <= 32; s++) send(2 * s);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        check("r28_valid", dout_valid, 0);
        check("r28_din_ready", din_ready, 0);
        check("r28_wr_done", tap_wr_done, 0);
        tick();
        reset = 1'b0;
        tick();
        base = n_out;
        load_taps(0);
        for (int s = 1; s <= 7; s++) send(10 * s);
        for (int i = 0; i < 100; i++) tick();
        check("r28_no_valid", dout_valid, 0);
        check("r28_no_out", n_out - base, 0);
        send(40);
        wait_out("r28_out", 20);
        tick(); tick();
        check("r28_count", n_out - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/downsample_8x_fir.md
DOWNSAMPLE_8X_FIR -- requirements
Module: downsample_8x_fir

Interface
REQ-001 SHALL have parameters: G_DWIDTH, 24, sample width (signed); G_TAP_RES, 16, tap width (signed Q1.15); G_NUM_TAPS, 63, FIR length; G_DECIM, 8, decimation factor.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  in  1  synchronous run enable; low is equivalent to reset.
REQ-005 SHALL have port tap_wr  in  1  tap write strobe, one tap per cycle.
REQ-006 SHALL have port tap_val  in  G_TAP_RES  tap value, written in index order 0..G_NUM_TAPS-1.
REQ-007 SHALL have port tap_wr_done  out  1  high once all G_NUM_TAPS taps are written.
REQ-008 SHALL have ports din / din_valid / din_ready  in/in/out  G_DWIDTH/1/1  input stream at the high rate.
REQ-009 SHALL have ports dout / dout_valid / dout_ready  out/out/in  G_DWIDTH/1/1  output stream at 1/G_DECIM rate.

Function
REQ-010 SHALL implement FSM states LOAD, ACCEPT, MAC, OUT; it enters LOAD from reset or enable low.
REQ-011 LOAD: each tap_wr high SHALL store tap_val at the next index; after write G_NUM_TAPS, tap_wr_done SHALL go high on the next cycle and the FSM SHALL enter ACCEPT; tap_wr SHALL be ignored outside LOAD.
REQ-012 ACCEPT: din_ready SHALL be 1; a sample SHALL be accepted on a cycle where din_valid && din_ready, written to a G_NUM_TAPS-deep circular delay line, and the write pointer SHALL wrap from G_NUM_TAPS-1 to 0.
REQ-013 A phase counter SHALL count accepted samples 0..G_DECIM-1 and wrap; acceptance at phase G_DECIM-1 SHALL move the FSM to MAC. Non-final phases SHALL produce no output.
REQ-014 MAC: din_ready SHALL be 0; one multiply-accumulate per cycle for G_NUM_TAPS cycles, with tap[k] applied to the sample accepted k samples before the newest (tap[0] multiplies the newest sample).
REQ-015 The accumulator SHALL be signed, G_DWIDTH+G_TAP_RES+6 bits, and cleared at MAC entry.
REQ-016 The result SHALL be acc arithmetic-shifted right by G_TAP_RES-1 and saturated to [-2^(G_DWIDTH-1), 2^(G_DWIDTH-1)-1] in one register stage.
REQ-017 dout_valid SHALL rise G_NUM_TAPS+2 cycles after the accepting edge of the phase G_DECIM-1 sample; the FSM SHALL then be in OUT.
REQ-018 OUT: dout and dout_valid SHALL hold stable until dout_valid && dout_ready; on that edge dout_valid SHALL drop and the FSM SHALL return to ACCEPT. din_ready SHALL be 0 in OUT.
REQ-019 Delay-line samples not yet written since reset SHALL read as zero.
REQ-020 A sample SHALL never be dropped or duplicated under any din_valid/dout_ready pattern.

Reset
REQ-021 reset high SHALL asynchronously force dout=0, dout_valid=0, din_ready=0, tap_wr_done=0, FSM=LOAD, tap index=0, phase=0, pointer=0, delay line=0.
REQ-022 enable low SHALL apply the REQ-021 values synchronously, including during MAC or OUT; the partial result SHALL be discarded and taps SHALL be reloaded.

Configuration
REQ-023 With macro DOWNSAMPLE_8X_FIR_ROUNDING_EN defined, 2^(G_TAP_RES-2) SHALL be added to acc before the shift (round half up); without it, the shift SHALL truncate toward negative infinity.

Verification
REQ-024 Write 63 taps -> tap_wr_done is 0 through the 63rd write, then 1; din_ready stays 0 until then.
REQ-025 tap[0]=16384, others 0; input 1,2,...,16 -> exactly two outputs, 4 and 8, each G_NUM_TAPS+2 cycles after samples 8 and 16.
REQ-026 All taps 32767, constant input 8388607 -> dout 8388607; constant input -8388608 -> dout -8388608 (saturated).
REQ-027 dout_ready held 0 for 20 cycles while dout_valid=1 -> dout stable and din_ready 0; after release, the next outputs match the reference model with no samples lost.
REQ-028 reset pulse during MAC -> dout_valid, din_ready and tap_wr_done are 0 in the same cycle; no output appears after taps are reloaded until 8 new samples are accepted.
REQ-029 tap[0]=16384, input 3 at phase 7 -> dout=2 with DOWNSAMPLE_8X_FIR_ROUNDING_EN defined, 1 without it.
